// File: rtl/popcount_feeder_pkg.sv
// rtl/popcount_feeder_pkg.sv - shared types and helpers for the popcount feeder
package popcount_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } state_t;

  // A WIDTH-bit word can have anywhere from 0 to WIDTH bits set.
  function automatic int result_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/popcount_feeder_fifo.sv
// rtl/popcount_feeder_fifo.sv - small synchronous FIFO with level count
module popcount_feeder_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       srst_i,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses a push even when a pop frees a slot the same cycle.
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign full      = (level == LW'(DEPTH));
  assign empty     = (level == '0);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/popcount_feeder.sv
// rtl/popcount_feeder.sv - paces words into a ready-less popcount counter
module popcount_feeder
  import popcount_feeder_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk_i,
  input  logic                             srst_i,
  input  logic [WIDTH-1:0]                 data_i,
  input  logic                             data_val_i,
  output logic                             data_ready_o,
  output logic [WIDTH-1:0]                 cnt_data_o,
  output logic                             cnt_data_val_o,
  input  logic [result_width(WIDTH)-1:0]   cnt_result_i,
  input  logic                             cnt_result_val_i,
  output logic [result_width(WIDTH)-1:0]   result_o,
  output logic                             result_val_o,
  input  logic                             result_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_level_o
);

  state_t           state;
  logic [WIDTH-1:0] fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;

  assign data_ready_o = !fifo_full;
  assign fifo_pop     = (state == IDLE) && !fifo_empty;

  popcount_feeder_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .srst_i    (srst_i),
    .push      (data_val_i),
    .push_data (data_i),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level_o)
  );

  // Counter done pulses outside WAIT belong to free-running or stale work.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state          <= IDLE;
      cnt_data_o     <= '0;
      cnt_data_val_o <= 1'b0;
      result_o       <= '0;
      result_val_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            cnt_data_o     <= fifo_head;
            cnt_data_val_o <= 1'b1;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_data_val_o <= 1'b0;
          state          <= WAIT;
        end
        WAIT: begin
          if (cnt_result_val_i) begin
            result_o     <= cnt_result_i;
            result_val_o <= 1'b1;
            state        <= OUT;
          end
        end
        OUT: begin
          if (result_ready_i) begin
            result_val_o <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_popcount_feeder.sv
// tb/tb_popcount_feeder.sv - scoreboard bench for popcount_feeder
module tb_popcount_feeder;

  localparam int WIDTH = 32;
  localparam int RW    = 6;
  localparam int LW    = 3;

  logic             clk_i = 1'b0;
  logic             srst_i;
  logic [WIDTH-1:0] data_i;
  logic             data_val_i;
  logic             data_ready_o;
  logic [WIDTH-1:0] cnt_data_o;
  logic             cnt_data_val_o;
  logic [RW-1:0]    cnt_result_i;
  logic             cnt_result_val_i;
  logic [RW-1:0]    result_o;
  logic             result_val_o;
  logic             result_ready_i;
  logic [LW-1:0]    fifo_level_o;

  popcount_feeder #(.WIDTH(WIDTH), .FIFO_DEPTH(4)) dut (
    .clk_i            (clk_i),
    .srst_i           (srst_i),
    .data_i           (data_i),
    .data_val_i       (data_val_i),
    .data_ready_o     (data_ready_o),
    .cnt_data_o       (cnt_data_o),
    .cnt_data_val_o   (cnt_data_val_o),
    .cnt_result_i     (cnt_result_i),
    .cnt_result_val_i (cnt_result_val_i),
    .result_o         (result_o),
    .result_val_o     (result_val_o),
    .result_ready_i   (result_ready_i),
    .fifo_level_o     (fifo_level_o)
  );

  always #5 clk_i = ~clk_i;

  int tests  = 0;
  int failed = 0;
  int exp_q[$];

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Counter model: WIDTH=32, PIPE_SIZE=8 gives a result 5 cycles after issue.
  logic          manual   = 1'b0;
  logic          man_val  = 1'b0;
  logic [RW-1:0] man_res  = '0;
  logic          stale_en = 1'b0;
  logic [2:0]    cd;
  logic [RW-1:0] pc;
  logic [2:0]    free_cnt = '0;
  logic          model_val;
  logic [RW-1:0] model_res;

  always @(posedge clk_i) begin
    free_cnt <= (free_cnt == 3'd6) ? 3'd0 : free_cnt + 3'd1;
    if (srst_i) cd <= '0;
    else if (cnt_data_val_o) begin
      cd <= 3'd5;
      pc <= RW'($countones(cnt_data_o));
    end else if (cd != 0) cd <= cd - 3'd1;
  end

  assign model_val        = (cd == 3'd1) || (stale_en && free_cnt == 3'd0);
  assign model_res        = (cd == 3'd1) ? pc : RW'(9);
  assign cnt_result_val_i = manual ? man_val : model_val;
  assign cnt_result_i     = manual ? man_res : model_res;

  // Monitor
  int            cyc = 0;
  int            issue_cnt = 0;
  int            valid_cnt = 0;
  int            issue_cyc = 0;
  int            first_valid_cyc = 0;
  int            ready_bad = 0;
  int            saw_full = 0;
  logic          prev_valid = 1'b0;
  logic          prev_ready = 1'b0;
  logic [RW-1:0] prev_res = '0;

  always @(posedge clk_i) cyc++;

  always @(negedge clk_i) begin
    if (srst_i) begin
      prev_valid = 1'b0;
    end else begin
      if (cnt_data_val_o) begin
        issue_cnt++;
        issue_cyc = cyc;
      end
      if (result_val_o) begin
        if (!prev_valid) first_valid_cyc = cyc;
        valid_cnt++;
      end
      if (data_ready_o != (fifo_level_o != 3'd4)) ready_bad++;
      if (fifo_level_o == 3'd4 && !data_ready_o) saw_full = 1;
      if (prev_valid && !prev_ready) begin
        check("held_valid", result_val_o, 1);
        check("held_result", result_o, prev_res);
      end
      if (result_val_o && result_ready_i) begin
        if (exp_q.size() == 0) check("unexpected_result", result_o, -1);
        else check("result", result_o, exp_q.pop_front());
      end
      prev_valid = result_val_o;
      prev_ready = result_ready_i;
      prev_res   = result_o;
    end
  end

  task automatic push(input logic [WIDTH-1:0] w, input int exp);
    int n = 0;
    data_i     = w;
    data_val_i = 1'b1;
    while (!data_ready_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 200) check("push_timeout", 0, 1);
    if (exp >= 0) exp_q.push_back(exp);
    @(negedge clk_i);
    data_val_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (!(exp_q.size() == 0 && fifo_level_o == 0 && !result_val_o && !cnt_data_val_o) && n < 500) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 500) check("drain_timeout", 0, 1);
    repeat (2) @(negedge clk_i);
  endtask

  task automatic wait_issue();
    int n = 0;
    while (!cnt_data_val_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 50) check("issue_timeout", 0, 1);
  endtask

  int i0, v0;

  initial begin
    srst_i = 1'b1; data_i = '0; data_val_i = 1'b0; result_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    srst_i = 1'b0;

    check("rst_data_ready", data_ready_o, 1);
    check("rst_cnt_data", cnt_data_o, 0);
    check("rst_cnt_val", cnt_data_val_o, 0);
    check("rst_result", result_o, 0);
    check("rst_result_val", result_val_o, 0);
    check("rst_level", fifo_level_o, 0);

    // Single word
    i0 = issue_cnt; v0 = valid_cnt;
    push(32'hFFFF_0001, 17);
    drain();
    check("single_issues", issue_cnt - i0, 1);
    check("single_valid_cycles", valid_cnt - v0, 1);
    check("single_latency", first_valid_cyc - issue_cyc, 6);
    check("single_level", fifo_level_o, 0);

    // Back-to-back burst; fifth word pushes the FIFO to full
    push(32'h0000_0000, 0);
    push(32'hFFFF_FFFF, 32);
    push(32'h0000_00FF, 8);
    push(32'h8000_0001, 2);
    push(32'h1234_5678, 13);
    drain();
    check("burst_saw_full", saw_full, 1);

    // Idle with a free-running counter
    i0 = issue_cnt; v0 = valid_cnt;
    stale_en = 1'b1;
    repeat (50) @(negedge clk_i);
    stale_en = 1'b0;
    check("stale_issues", issue_cnt - i0, 0);
    check("stale_valid", valid_cnt - v0, 0);

    // Done pulse coincident with ISSUE must be ignored
    manual = 1'b1;
    push(32'h0000_0FFF, 12);
    wait_issue();
    man_val = 1'b1; man_res = RW'(7);
    @(negedge clk_i);
    man_val = 1'b0;
    repeat (2) @(negedge clk_i);
    man_val = 1'b1; man_res = RW'(12);
    @(negedge clk_i);
    man_val = 1'b0;
    drain();
    manual = 1'b0;

    // Backpressure
    result_ready_i = 1'b0;
    i0 = issue_cnt;
    push(32'h0000_0003, 2);
    push(32'h0000_0007, 3);
    push(32'h0000_000F, 4);
    push(32'h0000_001F, 5);
    push(32'h0000_003F, 6);
    repeat (20) @(negedge clk_i);
    check("bp_issues", issue_cnt - i0, 1);
    check("bp_level", fifo_level_o, 4);
    check("bp_data_ready", data_ready_o, 0);
    check("bp_result_val", result_val_o, 1);
    check("bp_result", result_o, 2);
    result_ready_i = 1'b1;
    drain();

    // Reset while waiting on the counter with two words queued
    manual = 1'b1;
    push(32'h0000_0001, -1);
    push(32'h0000_0002, -1);
    push(32'h0000_0004, -1);
    check("mr_level_before", fifo_level_o, 2);
    check("mr_in_wait", cnt_data_val_o, 0);
    srst_i = 1'b1;
    @(negedge clk_i);
    srst_i = 1'b0;
    check("mr_level", fifo_level_o, 0);
    check("mr_result_val", result_val_o, 0);
    check("mr_cnt_val", cnt_data_val_o, 0);
    check("mr_data_ready", data_ready_o, 1);
    i0 = issue_cnt; v0 = valid_cnt;
    man_val = 1'b1; man_res = RW'(20);
    @(negedge clk_i);
    man_val = 1'b0;
    repeat (10) @(negedge clk_i);
    check("mr_no_result", valid_cnt - v0, 0);
    check("mr_no_issue", issue_cnt - i0, 0);

    check("scoreboard_empty", exp_q.size(), 0);
    check("ready_equals_not_full", ready_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
